// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
// Instruction-fetch controller between the PC register and decode. Issues
// one fetch at a time on a request/response memory port, advances the PC
// only when the request is accepted, and holds the returned word in a
// one-entry IF->ID slot with valid/allowin handshaking. A flush (exception
// or ERET) empties the slot and discards any response still in flight.
// Misaligned PCs are not fetched; they become an AdEL entry in the slot.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc, pc_en           current PC in, advance enable out
//   flush               redirect; PC loads the handler on the same edge
//   inst_req/addr       fetch request and address (address == pc)
//   inst_addr_ok        request accepted
//   inst_data_ok/rdata  read response
//   id_allowin          decode can take the slot this cycle
//   if_valid/pc/inst    slot contents presented to decode
//   if_adel             slot entry is a misaligned-fetch exception
module inst_fetch_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pc,
    output logic         pc_en,
    input  logic         flush,
    output logic         inst_req,
    output logic [N-1:0] inst_addr,
    input  logic         inst_addr_ok,
    input  logic         inst_data_ok,
    input  logic [N-1:0] inst_rdata,
    input  logic         id_allowin,
    output logic         if_valid,
    output logic [N-1:0] if_pc,
    output logic [N-1:0] if_inst,
    output logic         if_adel
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        EXC  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] req_pc_q, req_pc_d;
    logic         if_valid_q, if_valid_d;
    logic         if_adel_q, if_adel_d;
    logic [N-1:0] if_pc_q, if_pc_d;
    logic [N-1:0] if_inst_q, if_inst_d;

    logic free;
    logic aligned;
    logic req;

    // A new fetch may only start when its response is guaranteed a slot.
    assign free    = !if_valid_q || id_allowin;
    assign aligned = (pc[1:0] == 2'b00);
    // Reset is asynchronous, so the request is also masked while rst is high.
    assign req     = !rst && (state_q == REQ) && free && !flush && aligned;

    assign inst_req  = req;
    assign inst_addr = pc;
    assign pc_en     = req && inst_addr_ok;

    always_comb begin
        logic       load;
        logic [N-1:0] load_pc;
        logic [N-1:0] load_inst;
        logic       load_adel;

        state_d   = state_q;
        req_pc_d  = req_pc_q;
        load      = 1'b0;
        load_pc   = '0;
        load_inst = '0;
        load_adel = 1'b0;

        unique case (state_q)
            REQ: begin
                if (req && inst_addr_ok) begin
                    req_pc_d = pc;
                    state_d  = WAIT;
                end else if (!aligned && free && !flush) begin
                    load      = 1'b1;
                    load_pc   = pc;
                    load_adel = 1'b1;
                    state_d   = EXC;
                end
            end
            WAIT: begin
                if (flush) begin
                    // Response still owed by the bus must be swallowed.
                    state_d = inst_data_ok ? REQ : DROP;
                end else if (inst_data_ok) begin
                    load      = 1'b1;
                    load_pc   = req_pc_q;
                    load_inst = inst_rdata;
                    state_d   = REQ;
                end
            end
            DROP: begin
                if (inst_data_ok) begin
                    state_d = REQ;
                end
            end
            EXC: begin
                if (flush) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        if_valid_d = if_valid_q;
        if_adel_d  = if_adel_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        // Flush beats a same-edge load; a load beats a same-edge drain.
        if (flush) begin
            if_valid_d = 1'b0;
            if_adel_d  = 1'b0;
        end else if (load) begin
            if_valid_d = 1'b1;
            if_adel_d  = load_adel;
            if_pc_d    = load_pc;
            if_inst_d  = load_inst;
        end else if (if_valid_q && id_allowin) begin
            if_valid_d = 1'b0;
            if_adel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= REQ;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_adel_q  <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_adel_q  <= if_adel_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_adel  = if_adel_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] pc;
    logic         pc_en;
    logic         flush;
    logic         inst_req;
    logic [N-1:0] inst_addr;
    logic         inst_addr_ok;
    logic         inst_data_ok;
    logic [N-1:0] inst_rdata;
    logic         id_allowin;
    logic         if_valid;
    logic [N-1:0] if_pc;
    logic [N-1:0] if_inst;
    logic         if_adel;

    int checks;
    int errors;

    inst_fetch_ctrl #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .pc_en        (pc_en),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .id_allowin   (id_allowin),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'hbfc00000; flush = 1'b0;
        inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = '0;
        id_allowin = 1'b1;
        tick(); tick();
        #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", inst_req); end
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en got %0b want 0", pc_en); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", if_valid); end
        checks++; if (if_pc !== 32'h0 || if_inst !== 32'h0 || if_adel !== 1'b0) begin
            errors++; $display("FAIL reset_slot got pc=%h inst=%h adel=%0b want 0/0/0", if_pc, if_inst, if_adel); end
        inst_addr_ok = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL first_req got %0b want 1", inst_req); end
        checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL first_addr got %h want bfc00000", inst_addr); end
        tick();
    endtask

    task automatic test_single_fetch();
        // c1: request accepted
        inst_addr_ok = 1'b1;
        #1;
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL fetch_pc_en_c1 got %0b want 1", pc_en); end
        tick();
        pc = 32'hbfc00004;
        // c2: waiting; addr_ok held high must not advance the PC
        #1;
        checks++; if (inst_req !== 1'b0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL fetch_wait_c2 got req=%0b pc_en=%0b want 0/0", inst_req, pc_en); end
        tick();
        // c3: response
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c08bfc0;
        #1;
        checks++; if (pc_en !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_c3 got pc_en=%0b valid=%0b want 0/0", pc_en, if_valid); end
        tick();
        // c4: slot filled, next request already up
        inst_data_ok = 1'b0; inst_rdata = 32'h0;
        #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %0b want 1", if_valid); end
        checks++; if (if_pc !== 32'hbfc00000) begin errors++; $display("FAIL fetch_if_pc got %h want bfc00000", if_pc); end
        checks++; if (if_inst !== 32'h3c08bfc0) begin errors++; $display("FAIL fetch_if_inst got %h want 3c08bfc0", if_inst); end
        checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL fetch_adel got %0b want 0", if_adel); end
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00004) begin
            errors++; $display("FAIL fetch_next_req got req=%0b addr=%h want 1/bfc00004", inst_req, inst_addr); end
    endtask

    task automatic test_backpressure();
        id_allowin = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL bp_req_now got %0b want 0", inst_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (inst_req !== 1'b0 || if_valid !== 1'b1 || if_inst !== 32'h3c08bfc0) begin
                errors++; $display("FAIL bp_hold_%0d got req=%0b valid=%0b inst=%h want 0/1/3c08bfc0", i, inst_req, if_valid, if_inst); end
        end
        id_allowin = 1'b1;
        #1;
        checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL bp_release_req got %0b want 1", inst_req); end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; pc = 32'hbfc00008;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", if_valid); end
    endtask

    task automatic test_flush_in_flight();
        // in WAIT for the bfc00004 fetch
        flush = 1'b1;
        #1;
        checks++; if (inst_req !== 1'b0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL fl_req got req=%0b pc_en=%0b want 0/0", inst_req, pc_en); end
        tick();
        flush = 1'b0; pc = 32'hbfc00380;
        #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL fl_drop_req got %0b want 0", inst_req); end
        tick();
        inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
        #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL fl_drop_req2 got %0b want 0", inst_req); end
        tick();
        inst_data_ok = 1'b0; inst_rdata = 32'h0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0b want 0", if_valid); end
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin
            errors++; $display("FAIL fl_resume got req=%0b addr=%h want 1/bfc00380", inst_req, inst_addr); end
    endtask

    task automatic test_flush_with_data();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; pc = 32'hbfc00384;
        flush = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
        tick();
        flush = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0; pc = 32'hbfc00380;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fd_valid got %0b want 0", if_valid); end
        checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL fd_no_drop got req=%0b want 1", inst_req); end
        // a clean fetch afterwards
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; pc = 32'hbfc00384;
        inst_data_ok = 1'b1; inst_rdata = 32'h24020001;
        tick();
        inst_data_ok = 1'b0; inst_rdata = 32'h0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00380 || if_inst !== 32'h24020001) begin
            errors++; $display("FAIL fd_refetch got valid=%0b pc=%h inst=%h want 1/bfc00380/24020001", if_valid, if_pc, if_inst); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fd_drain got %0b want 0", if_valid); end
    endtask

    task automatic test_misaligned();
        pc = 32'hbfc00002; inst_addr_ok = 1'b1;
        #1;
        checks++; if (inst_req !== 1'b0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL mis_req got req=%0b pc_en=%0b want 0/0", inst_req, pc_en); end
        tick();
        id_allowin = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_adel !== 1'b1 || if_inst !== 32'h0 || if_pc !== 32'hbfc00002) begin
            errors++; $display("FAIL mis_slot got valid=%0b adel=%0b inst=%h pc=%h want 1/1/0/bfc00002", if_valid, if_adel, if_inst, if_pc); end
        pc = 32'hbfc00000;
        #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL mis_exc_hold got %0b want 0", inst_req); end
        id_allowin = 1'b1;
        tick();
        checks++; if (inst_req !== 1'b0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL mis_exc_hold2 got req=%0b pc_en=%0b want 0/0", inst_req, pc_en); end
        flush = 1'b1;
        tick();
        flush = 1'b0; pc = 32'hbfc00380; inst_addr_ok = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || if_adel !== 1'b0) begin
            errors++; $display("FAIL mis_flush_slot got valid=%0b adel=%0b want 0/0", if_valid, if_adel); end
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin
            errors++; $display("FAIL mis_resume got req=%0b addr=%h want 1/bfc00380", inst_req, inst_addr); end
    endtask

    task automatic test_reset_mid();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; pc = 32'hbfc00384;
        inst_data_ok = 1'b1; inst_rdata = 32'h8c010000;
        tick();
        inst_data_ok = 1'b0; inst_rdata = 32'h0; id_allowin = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL rm_pre got %0b want 1", if_valid); end
        rst = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || inst_req !== 1'b0) begin
            errors++; $display("FAIL rm_async got valid=%0b pc=%h inst=%h req=%0b want 0/0/0/0", if_valid, if_pc, if_inst, inst_req); end
        tick();
        rst = 1'b0; pc = 32'hbfc00000; id_allowin = 1'b1;
        #1;
        checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin
            errors++; $display("FAIL rm_restart got req=%0b addr=%h want 1/bfc00000", inst_req, inst_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_flush_in_flight();
        test_flush_with_data();
        test_misaligned();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch controller sitting directly downstream of the PC register. Turns the current `pc` into requests on the request/response instruction-memory port and advances the PC only when a request is accepted. Captures the returned instruction into a one-entry IF→ID slot with valid/allowin flow control. Handles exception flush, including responses still in flight, and raises AdEL on misaligned fetch addresses.

## Interface
Parameters:
- `N`, 32, address/data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `pc`  in  N  current PC, from the PC register.
- `pc_en`  out  1  PC advance enable, to PC `en`.
- `flush`  in  1  exception/ERET redirect; PC loads the handler address on this same edge.
- `inst_req`  out  1  fetch request valid.
- `inst_addr`  out  N  fetch address; always equals `pc`.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  N  read data.
- `id_allowin`  in  1  decode stage can take the slot this cycle.
- `if_valid`  out  1  slot holds an instruction for ID.
- `if_pc`  out  N  PC of the slot instruction.
- `if_inst`  out  N  instruction word in the slot.
- `if_adel`  out  1  slot entry is a misaligned-fetch exception.

## Operation
FSM states are REQ, WAIT, DROP and EXC. Reset enters REQ.

- Slot-free term: `free = !if_valid | id_allowin`.
- The slot drains when `if_valid & id_allowin`; on that edge `if_valid` clears unless the slot is refilled on the same edge.

REQ:
- `inst_req = free & !flush & (pc[1:0]==0)`.
- On `inst_req & inst_addr_ok`: latch `req_pc <= pc` and go to WAIT.
- If `pc[1:0]!=0 & free & !flush`:
  - no bus request is made;
  - slot is loaded with `if_valid=1`, `if_adel=1`, `if_inst=0`, `if_pc=pc`;
  - go to EXC.

WAIT:
- `inst_req=0`.
- On `inst_data_ok & !flush`: load the slot with `if_valid=1`, `if_pc=req_pc`, `if_inst=inst_rdata`, `if_adel=0`, and go to REQ.
- On `flush & inst_data_ok`: discard the data and go to REQ.
- On `flush & !inst_data_ok`: go to DROP.

DROP:
- `inst_req=0`.
- On `inst_data_ok`: discard the data and go to REQ.
- `flush` has no further effect in this state.

EXC:
- `inst_req=0`. Hold until `flush`, then go to REQ.

Flow control and flush rules:
- `pc_en = inst_req & inst_addr_ok`. It never asserts in WAIT, DROP or EXC.
- `flush` in any state clears `if_valid` and `if_adel` on that edge, and takes priority over a slot load.
- At most one request is outstanding.
- The `free` gating guarantees the slot is empty when `inst_data_ok` arrives, so no skid buffer is needed.
- `inst_data_ok` is ignored in REQ and EXC.

## Timing
- Reset values:
  - state = REQ, `req_pc=0`;
  - `if_valid=0`, `if_adel=0`, `if_pc=0`, `if_inst=0`;
  - `inst_req=0` and `pc_en=0` while `rst` is high.
- First request is in the first cycle after `rst` falls, with `inst_addr=pc` (0xbfc00000).
- Bus latency: request accepted at cycle t, `inst_data_ok` at t+k with k≥1, `if_valid` high at t+k+1.
- Best-case throughput is one instruction per 2 cycles.
- Next request may assert in the same cycle `if_valid` rises, provided `id_allowin=1`.
- `inst_addr`, `pc_en` and `inst_req` are combinational from `pc`, state, `if_valid`, `id_allowin`, `flush` and `inst_addr_ok`. The slot outputs are registered.
- `rst` mid-operation clears all state immediately. The memory port is reset by the same `rst`, so no stale response follows.

## Test plan
- **Reset:** `rst=1` → `inst_req=0`, `pc_en=0`, `if_valid=0`. Release with `pc=0xbfc00000` → next cycle `inst_req=1`, `inst_addr=0xbfc00000`.
- **Single fetch:** `addr_ok` at c1, `data_ok` at c3 with `rdata=0x3c08bfc0` → `pc_en` high only in c1; in c4 `if_valid=1`, `if_pc=0xbfc00000`, `if_inst=0x3c08bfc0`.
- **Backpressure:** slot full with `id_allowin=0` for 3 cycles → `inst_req=0` and `if_inst` stable. Set `id_allowin=1` → `inst_req=1` in the same cycle.
- **Flush in flight:** `flush` in WAIT, `data_ok` with `rdata=0xdeadbeef` 2 cycles later → `if_valid` stays 0. Next request is issued with `inst_addr=0xbfc00380`.
- **Flush coincident with data:** `flush` and `data_ok` in the same cycle → data dropped, state REQ next cycle, no DROP wait.
- **Misaligned PC:** `pc=0xbfc00002` → `inst_req=0`, `pc_en=0`, then `if_valid=1`, `if_adel=1`, `if_inst=0`. No requests until `flush`; after `flush`, fetch resumes at the new `pc`.
